// File: rtl/axil_arbiter_wr_if.sv
// rtl/axil_arbiter_wr_if.sv - request/grant bundle between masters, slaves and the write arbiter
// Purpose: groups the AW request, B completion and grant routing signals of the write arbiter.
// Signals:
//   m_axil_awaddr        per-master AW address (NUMBER_MASTER x AXI_ADDR_WIDTH)
//   m_axil_awvalid       per-master AW valid, used as the arbitration request
//   s_axil_bvalid        per-slave B valid
//   s_axil_bready        per-slave B ready as driven by the crossbar
//   grant_wr             master index routed to each slave
//   grant_wr_valid       per-slave grant live flag
//   grant_wr_trans       slave index routed to each master
//   grant_wr_trans_valid per-master grant live flag
// Modports: master drives requests/completions, slave (the arbiter) drives grants.
interface axil_arbiter_wr_if #(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 8
);
  logic [NUMBER_MASTER-1:0][AXI_ADDR_WIDTH-1:0]        m_axil_awaddr;
  logic [NUMBER_MASTER-1:0]                            m_axil_awvalid;
  logic [NUMBER_SLAVE-1:0]                             s_axil_bvalid;
  logic [NUMBER_SLAVE-1:0]                             s_axil_bready;
  logic [NUMBER_SLAVE-1:0][$clog2(NUMBER_MASTER)-1:0]  grant_wr;
  logic [NUMBER_SLAVE-1:0]                             grant_wr_valid;
  logic [NUMBER_MASTER-1:0][$clog2(NUMBER_SLAVE)-1:0]  grant_wr_trans;
  logic [NUMBER_MASTER-1:0]                            grant_wr_trans_valid;

  modport master (
    output m_axil_awaddr, m_axil_awvalid, s_axil_bvalid, s_axil_bready,
    input  grant_wr, grant_wr_valid, grant_wr_trans, grant_wr_trans_valid
  );

  modport slave (
    input  m_axil_awaddr, m_axil_awvalid, s_axil_bvalid, s_axil_bready,
    output grant_wr, grant_wr_valid, grant_wr_trans, grant_wr_trans_valid
  );
endinterface

// File: rtl/axil_arbiter_wr.sv
// rtl/axil_arbiter_wr.sv - per-slave round-robin write arbiter holding grants for a full AW->W->B transaction
// Purpose: decodes each master's AW address to a slave, arbitrates per slave round-robin and holds
//          the grant until that slave's B handshake.
// Ports:
//   aclk    clock, all state on rising edge
//   aresetn asynchronous active-low reset
//   arb     request/grant bundle (slave modport): awaddr/awvalid/bvalid/bready in, grants out
module axil_arbiter_wr #(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  axil_arbiter_wr_if.slave    arb
);
  localparam int MIW = $clog2(NUMBER_MASTER);
  localparam int SIW = $clog2(NUMBER_SLAVE);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q [NUMBER_SLAVE];
  state_t         state_d [NUMBER_SLAVE];
  logic [MIW-1:0] owner_q [NUMBER_SLAVE];
  logic [MIW-1:0] owner_d [NUMBER_SLAVE];
  logic [MIW-1:0] ptr_q   [NUMBER_SLAVE];
  logic [MIW-1:0] ptr_d   [NUMBER_SLAVE];

  logic [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0] req;
  logic [NUMBER_SLAVE-1:0]                    pick_vld;
  logic [MIW-1:0]                             pick_idx [NUMBER_SLAVE];

  // A master already holding a grant is masked out, so it can never win a second slave.
  always_comb begin
    req = '0;
    for (int s = 0; s < NUMBER_SLAVE; s++) begin
      for (int m = 0; m < NUMBER_MASTER; m++) begin
        req[s][m] = arb.m_axil_awvalid[m] &&
                    (arb.m_axil_awaddr[m][AXI_ADDR_WIDTH-1 -: SIW] == SIW'(s)) &&
                    !arb.grant_wr_trans_valid[m];
      end
    end
  end

  // Round-robin pick: first requester scanning upward from the last winner + 1.
  always_comb begin
    pick_vld = '0;
    for (int s = 0; s < NUMBER_SLAVE; s++) begin
      pick_idx[s] = '0;
      for (int i = 1; i <= NUMBER_MASTER; i++) begin
        if (!pick_vld[s] && req[s][(int'(ptr_q[s]) + i) % NUMBER_MASTER]) begin
          pick_vld[s] = 1'b1;
          pick_idx[s] = MIW'((int'(ptr_q[s]) + i) % NUMBER_MASTER);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int s = 0; s < NUMBER_SLAVE; s++) begin
        state_q[s] <= IDLE;
        owner_q[s] <= '0;
        ptr_q[s]   <= MIW'(NUMBER_MASTER - 1);
      end
    end else begin
      for (int s = 0; s < NUMBER_SLAVE; s++) begin
        state_q[s] <= state_d[s];
        owner_q[s] <= owner_d[s];
        ptr_q[s]   <= ptr_d[s];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUMBER_SLAVE; s++) begin
      state_d[s] = state_q[s];
      owner_d[s] = owner_q[s];
      ptr_d[s]   = ptr_q[s];
      case (state_q[s])
        IDLE: begin
          // B handshakes seen while idle are stray and deliberately ignored.
          if (pick_vld[s]) begin
            state_d[s] = BUSY;
            owner_d[s] = pick_idx[s];
            ptr_d[s]   = pick_idx[s];
          end
        end
        BUSY: begin
          if (arb.s_axil_bvalid[s] && arb.s_axil_bready[s]) begin
            state_d[s] = IDLE;
          end
        end
        default: state_d[s] = IDLE;
      endcase
    end
  end

  // Outputs come only from registered state; index fields read 0 whenever not valid.
  always_comb begin
    arb.grant_wr             = '0;
    arb.grant_wr_valid       = '0;
    arb.grant_wr_trans       = '0;
    arb.grant_wr_trans_valid = '0;
    for (int s = 0; s < NUMBER_SLAVE; s++) begin
      if (state_q[s] == BUSY) begin
        arb.grant_wr[s]       = owner_q[s];
        arb.grant_wr_valid[s] = 1'b1;
      end
    end
    for (int m = 0; m < NUMBER_MASTER; m++) begin
      for (int s = 0; s < NUMBER_SLAVE; s++) begin
        if ((state_q[s] == BUSY) && (owner_q[s] == MIW'(m))) begin
          arb.grant_wr_trans[m]       = SIW'(s);
          arb.grant_wr_trans_valid[m] = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axil_arbiter_wr.sv
// tb/tb_axil_arbiter_wr.sv - directed self-checking bench for axil_arbiter_wr
module tb_axil_arbiter_wr;
  logic aclk;
  logic aresetn;
  int   total;
  int   bad;

  axil_arbiter_wr_if #(.NUMBER_MASTER(2), .NUMBER_SLAVE(4), .AXI_ADDR_WIDTH(8)) arb ();

  axil_arbiter_wr #(.NUMBER_MASTER(2), .NUMBER_SLAVE(4), .AXI_ADDR_WIDTH(8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arb     (arb)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all four grant outputs as flat vectors:
  // gw = grant_wr {s3,s2,s1,s0}, gv = grant_wr_valid, gt = grant_wr_trans {m1[1:0],m0[1:0]}, tv = trans_valid.
  task automatic chk_all(input string tag, input logic [3:0] gw, input logic [3:0] gv,
                         input logic [3:0] gt, input logic [1:0] tv);
    chk({tag, ".grant_wr"},             32'(arb.grant_wr),             32'(gw));
    chk({tag, ".grant_wr_valid"},       32'(arb.grant_wr_valid),       32'(gv));
    chk({tag, ".grant_wr_trans"},       32'(arb.grant_wr_trans),       32'(gt));
    chk({tag, ".grant_wr_trans_valid"}, 32'(arb.grant_wr_trans_valid), 32'(tv));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #3;
    chk_all("reset", 4'h0, 4'h0, 4'h0, 2'b00);
    aresetn = 1'b1;
    cyc(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    aresetn = 1'b0;
    arb.m_axil_awaddr  = '0;
    arb.m_axil_awvalid = '0;
    arb.s_axil_bvalid  = '0;
    arb.s_axil_bready  = '0;
    #12;
    do_reset();

    // 1: single master to slave 0, held until B handshake
    arb.m_axil_awaddr[0] = 8'h10;
    arb.m_axil_awvalid   = 2'b01;
    cyc(1);
    chk_all("t1_grant", 4'h0, 4'b0001, 4'h0, 2'b01);
    arb.m_axil_awvalid = 2'b00;
    cyc(3);
    chk_all("t1_hold", 4'h0, 4'b0001, 4'h0, 2'b01);
    arb.s_axil_bvalid = 4'b0001;
    arb.s_axil_bready = 4'b0001;
    cyc(1);
    arb.s_axil_bvalid = '0;
    arb.s_axil_bready = '0;
    chk_all("t1_release", 4'h0, 4'h0, 4'h0, 2'b00);

    // 2: tie on slave 2 after reset, M0 first then M1 after one idle cycle
    do_reset();
    arb.m_axil_awaddr[0] = 8'hAA;
    arb.m_axil_awaddr[1] = 8'hBB;
    arb.m_axil_awvalid   = 2'b11;
    cyc(1);
    chk_all("t2_first", 4'h0, 4'b0100, 4'b0010, 2'b01);
    arb.m_axil_awvalid = 2'b10;
    cyc(2);
    chk_all("t2_hold", 4'h0, 4'b0100, 4'b0010, 2'b01);
    arb.s_axil_bvalid = 4'b0100;
    arb.s_axil_bready = 4'b0100;
    cyc(1);
    arb.s_axil_bvalid = '0;
    arb.s_axil_bready = '0;
    chk_all("t2_idle", 4'h0, 4'h0, 4'h0, 2'b00);
    cyc(1);
    chk_all("t2_second", 4'b0100, 4'b0100, 4'b1000, 2'b10);
    arb.m_axil_awvalid = 2'b00;
    arb.s_axil_bvalid = 4'b0100;
    arb.s_axil_bready = 4'b0100;
    cyc(1);
    arb.s_axil_bvalid = '0;
    arb.s_axil_bready = '0;
    chk_all("t2_release", 4'h0, 4'h0, 4'h0, 2'b00);

    // 3: independent slaves granted in the same cycle
    arb.m_axil_awaddr[0] = 8'h10;
    arb.m_axil_awaddr[1] = 8'hC0;
    arb.m_axil_awvalid   = 2'b11;
    cyc(1);
    chk_all("t3_both", 4'b1000, 4'b1001, 4'b1100, 2'b11);
    arb.m_axil_awvalid = 2'b00;
    arb.s_axil_bvalid = 4'b1001;
    arb.s_axil_bready = 4'b1001;
    cyc(1);
    arb.s_axil_bvalid = '0;
    arb.s_axil_bready = '0;
    chk_all("t3_release", 4'h0, 4'h0, 4'h0, 2'b00);

    // 4: continuous contention on slave 2 alternates M0,M1,M0,M1
    arb.m_axil_awaddr[0] = 8'h80;
    arb.m_axil_awaddr[1] = 8'h9F;
    arb.m_axil_awvalid   = 2'b11;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) chk_all($sformatf("t4_grant%0d", k), 4'b0000, 4'b0100, 4'b0010, 2'b01);
      else            chk_all($sformatf("t4_grant%0d", k), 4'b0100, 4'b0100, 4'b1000, 2'b10);
      cyc(1);
      arb.s_axil_bvalid = 4'b0100;
      arb.s_axil_bready = 4'b0100;
      cyc(1);
      arb.s_axil_bvalid = '0;
      arb.s_axil_bready = '0;
      chk($sformatf("t4_idle%0d", k), 32'(arb.grant_wr_valid), 32'h0);
      if (k == 3) arb.m_axil_awvalid = 2'b00;
      cyc(1);
    end
    chk_all("t4_done", 4'h0, 4'h0, 4'h0, 2'b00);

    // 5: stray B on idle slave 1 ignored; grant held through a long stall
    arb.m_axil_awaddr[0] = 8'h40;
    arb.m_axil_awvalid   = 2'b01;
    arb.s_axil_bvalid    = 4'b0010;
    arb.s_axil_bready    = 4'b0010;
    cyc(1);
    arb.s_axil_bvalid = '0;
    arb.s_axil_bready = '0;
    chk_all("t5_grant", 4'h0, 4'b0010, 4'b0001, 2'b01);
    arb.m_axil_awvalid   = 2'b10;
    arb.m_axil_awaddr[1] = 8'h50;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk($sformatf("t5_stall%0d.grant_wr", k), 32'(arb.grant_wr), 32'h0);
      chk($sformatf("t5_stall%0d.valid", k), 32'(arb.grant_wr_valid), 32'b0010);
    end
    arb.s_axil_bvalid = 4'b0010;
    arb.s_axil_bready = 4'b0010;
    cyc(1);
    arb.s_axil_bvalid = '0;
    arb.s_axil_bready = '0;
    chk_all("t5_idle", 4'h0, 4'h0, 4'h0, 2'b00);
    cyc(1);
    chk_all("t5_m1", 4'b0010, 4'b0010, 4'b0100, 2'b10);
    arb.m_axil_awvalid = 2'b00;
    cyc(1);

    // 6: asynchronous reset while busy, then a tie on slave 0 (M0 won it last before reset)
    #2;
    aresetn = 1'b0;
    #1;
    chk_all("t6_async", 4'h0, 4'h0, 4'h0, 2'b00);
    #2;
    aresetn = 1'b1;
    arb.m_axil_awaddr[0] = 8'h00;
    arb.m_axil_awaddr[1] = 8'h20;
    arb.m_axil_awvalid   = 2'b11;
    cyc(1);
    chk_all("t6_tie", 4'h0, 4'b0001, 4'h0, 2'b01);
    arb.m_axil_awvalid = 2'b00;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
